// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the BIST pulse-train controller.
package pulse_train_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int PCNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_H = 2'd1,
        RUN_L = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_train_ctrl_counter_nb.sv
// Generic up-counter with synchronous reset, synchronous clear and count enable.
module counter_nb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pulse_train_ctrl.sv
// BIST pulse-train controller: bursts of high/low pulses launched by a start edge.
// Defining PULSE_TRAIN_DONE_IRQ_EN adds the one-cycle done_irq strobe output.
module pulse_train_ctrl
    import pulse_train_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic [PCNT_W-1:0] cfg_pulses,
    input  logic              cfg_repeat,
    output logic              out,
    output logic              running,
    output logic              bist_end,
    output logic              aborted,
    output logic [PCNT_W-1:0] pulse_idx
`ifdef PULSE_TRAIN_DONE_IRQ_EN
    ,
    output logic              done_irq
`endif
);

    state_t              state;
    state_t              state_next;
    logic                start_q;
    logic                pos_start;
    logic [CNT_W-1:0]    h_last;
    logic [CNT_W-1:0]    l_last;
    logic [PCNT_W-1:0]   p_last;
    logic                rep_q;
    logic [CNT_W-1:0]    len_cnt;
    logic [PCNT_W-1:0]   pulse_cnt;
    logic                launch;
    logic                h_end;
    logic                l_end;
    logic                last_pulse;
    logic                len_clear;
    logic                pulse_clear;
    logic                pulse_en;

    // start_q resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q   <= 1'b1;
            pos_start <= 1'b0;
        end else begin
            start_q   <= start;
            pos_start <= start & ~start_q;
        end
    end

    assign launch     = pos_start && (state == IDLE || state == DONE);
    assign h_end      = (len_cnt == h_last);
    assign l_end      = (len_cnt == l_last);
    assign last_pulse = (pulse_cnt == p_last);

    // Lengths are stored as last-count values; a zero length behaves as one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_last <= '0;
            l_last <= '0;
            p_last <= '0;
            rep_q  <= 1'b0;
        end else if (launch) begin
            h_last <= (cfg_high == '0) ? '0 : cfg_high - CNT_W'(1);
            l_last <= (cfg_low == '0) ? '0 : cfg_low - CNT_W'(1);
            p_last <= cfg_pulses - PCNT_W'(1);
            rep_q  <= cfg_repeat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (pos_start) begin
                    state_next = (cfg_pulses == '0) ? DONE : RUN_H;
                end
            end
            RUN_H: begin
                if (abort) begin
                    state_next = DONE;
                end else if (h_end) begin
                    state_next = (last_pulse && !rep_q) ? DONE : RUN_L;
                end
            end
            RUN_L: begin
                if (abort) begin
                    state_next = DONE;
                end else if (l_end) begin
                    state_next = RUN_H;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out      = 1'b0;
        running  = 1'b0;
        bist_end = 1'b0;
        case (state)
            RUN_H: begin
                out     = 1'b1;
                running = 1'b1;
            end
            RUN_L:   running  = 1'b1;
            DONE:    bist_end = 1'b1;
            default: ;
        endcase
    end

    // Every state change starts a phase from zero, including entry from IDLE/DONE.
    assign len_clear   = (state_next != state);
    assign pulse_en    = (state == RUN_L) && l_end && !abort;
    assign pulse_clear = launch || (pulse_en && last_pulse);

    counter_nb #(.W(CNT_W)) u_len_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (len_clear),
        .en    (running),
        .count (len_cnt)
    );

    counter_nb #(.W(PCNT_W)) u_pulse_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (pulse_clear),
        .en    (pulse_en),
        .count (pulse_cnt)
    );

    assign pulse_idx = pulse_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else if (running && abort) begin
            aborted <= 1'b1;
        end else if (launch) begin
            aborted <= 1'b0;
        end
    end

`ifdef PULSE_TRAIN_DONE_IRQ_EN
    // A relaunch from DONE that lands back in DONE (empty burst) is a fresh entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_irq <= 1'b0;
        end else begin
            done_irq <= (state_next == DONE) && (state != DONE || launch);
        end
    end
`endif

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Randomised and directed bench for pulse_train_ctrl against a queue-based burst model.
module tb_pulse_train_ctrl;

    localparam int CNT_W  = 8;
    localparam int PCNT_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_low;
    logic [PCNT_W-1:0] cfg_pulses;
    logic              cfg_repeat;
    logic              out;
    logic              running;
    logic              bist_end;
    logic              aborted;
    logic [PCNT_W-1:0] pulse_idx;
`ifdef PULSE_TRAIN_DONE_IRQ_EN
    logic              done_irq;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit o;
        int idx;
    } beat_t;

    beat_t exp_q[$];

    pulse_train_ctrl #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .cfg_pulses (cfg_pulses),
        .cfg_repeat (cfg_repeat),
        .out        (out),
        .running    (running),
        .bist_end   (bist_end),
        .aborted    (aborted),
        .pulse_idx  (pulse_idx)
`ifdef PULSE_TRAIN_DONE_IRQ_EN
        ,
        .done_irq   (done_irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One burst: the expected out/pulse_idx sequence is built from the H/L/P rules,
    // then compared cycle by cycle; abort_at >= 0 raises abort in that burst cycle.
    task automatic run_burst(input int h, input int l, input int p, input bit rep,
                             input int n_chk, input int abort_at);
        int  he;
        int  le;
        int  len;
        int  stop;
        int  k;
        bit  exp_ab;
        beat_t b;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        exp_q.delete();
        if (!rep) begin
            for (int pi = 0; pi < p; pi++) begin
                for (int c = 0; c < he; c++) begin b.o = 1'b1; b.idx = pi; exp_q.push_back(b); end
                if (pi < p - 1)
                    for (int c = 0; c < le; c++) begin b.o = 1'b0; b.idx = pi; exp_q.push_back(b); end
            end
        end else if (p > 0) begin
            k = 0;
            while (exp_q.size() < n_chk) begin
                for (int c = 0; c < he; c++) begin b.o = 1'b1; b.idx = k; exp_q.push_back(b); end
                for (int c = 0; c < le; c++) begin b.o = 1'b0; b.idx = k; exp_q.push_back(b); end
                k = (k + 1) % p;
            end
        end
        len    = (rep && p > 0) ? n_chk : exp_q.size();
        stop   = (abort_at >= 0) ? abort_at : len - 1;
        exp_ab = 1'b0;

        @(negedge clk);
        cfg_high   = CNT_W'(h);
        cfg_low    = CNT_W'(l);
        cfg_pulses = PCNT_W'(p);
        cfg_repeat = rep;
        abort      = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        check("launch_gap_running", 32'(running), 32'd0);
        check("launch_gap_out", 32'(out), 32'd0);

        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("burst_out", 32'(out), 32'(exp_q[i].o));
            check("burst_running", 32'(running), 32'd1);
            check("burst_idx", 32'(pulse_idx), 32'(exp_q[i].idx));
            check("burst_aborted", 32'(aborted), 32'd0);
            if (i == 1) begin
                cfg_high   = CNT_W'($urandom);
                cfg_low    = CNT_W'($urandom);
                cfg_pulses = PCNT_W'($urandom);
                cfg_repeat = 1'($urandom);
            end
            if (stop >= 4 && i == stop / 2)     start = 1'b0;
            if (stop >= 4 && i == stop / 2 + 1) start = 1'b1;
            if (i == abort_at) begin
                abort  = 1'b1;
                exp_ab = 1'b1;
                break;
            end
        end

        @(negedge clk);
        abort = 1'b0;
        check("done_bist_end", 32'(bist_end), 32'd1);
        check("done_aborted", 32'(aborted), 32'(exp_ab));
        check("done_out", 32'(out), 32'd0);
        check("done_running", 32'(running), 32'd0);
`ifdef PULSE_TRAIN_DONE_IRQ_EN
        check("done_irq_first", 32'(done_irq), 32'd1);
`endif
        start = 1'b0;
        @(negedge clk);
        check("done_hold_bist_end", 32'(bist_end), 32'd1);
        check("done_hold_aborted", 32'(aborted), 32'(exp_ab));
`ifdef PULSE_TRAIN_DONE_IRQ_EN
        check("done_irq_second", 32'(done_irq), 32'd0);
`endif
    endtask

    initial begin
        int h;
        int l;
        int p;
        int n;
        int len;
        int ab;
        bit rep;

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_high   = '0;
        cfg_low    = '0;
        cfg_pulses = '0;
        cfg_repeat = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(out), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_bist_end", 32'(bist_end), 32'd0);
        check("reset_aborted", 32'(aborted), 32'd0);
        check("reset_idx", 32'(pulse_idx), 32'd0);
`ifdef PULSE_TRAIN_DONE_IRQ_EN
        check("reset_done_irq", 32'(done_irq), 32'd0);
`endif
        reset = 1'b0;

        // Directed cases from the test plan.
        run_burst(3, 2, 2, 1'b0, 0, -1);
        run_burst(0, 0, 3, 1'b0, 0, -1);
        run_burst(5, 5, 0, 1'b0, 0, -1);
        run_burst(4, 4, 5, 1'b0, 0, 13);
        run_burst(4, 4, 5, 1'b0, 0, -1);
        run_burst(2, 1, 2, 1'b1, 14, 13);
        run_burst(2, 2, 2, 1'b0, 0, 5);

        // Start held high across reset release must not launch a burst.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("held_start_running", 32'(running), 32'd0);
            check("held_start_bist_end", 32'(bist_end), 32'd0);
        end
        start = 1'b0;

        // Reset in the middle of RUN_H.
        @(negedge clk);
        cfg_high   = 8'd5;
        cfg_low    = 8'd5;
        cfg_pulses = 8'd3;
        cfg_repeat = 1'b0;
        start      = 1'b1;
        repeat (3) @(negedge clk);
        check("midrun_out_before", 32'(out), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_out", 32'(out), 32'd0);
        check("midrun_reset_running", 32'(running), 32'd0);
        check("midrun_reset_bist_end", 32'(bist_end), 32'd0);
        check("midrun_reset_aborted", 32'(aborted), 32'd0);
        check("midrun_reset_idx", 32'(pulse_idx), 32'd0);
`ifdef PULSE_TRAIN_DONE_IRQ_EN
        check("midrun_reset_done_irq", 32'(done_irq), 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;

        // Randomised bursts.
        for (int t = 0; t < 12; t++) begin
            h   = int'($urandom_range(0, 4));
            l   = int'($urandom_range(0, 4));
            p   = int'($urandom_range(0, 4));
            rep = 1'($urandom);
            if (rep) begin
                n  = int'($urandom_range(4, 30));
                ab = n - 1;
            end else begin
                n   = 0;
                len = (p == 0) ? 0 : p * ((h == 0) ? 1 : h) + (p - 1) * ((l == 0) ? 1 : l);
                ab  = (len > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            end
            run_burst(h, l, p, rep, n, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
